// File: rtl/usb_rx_pkt_pkg.sv
// usb_rx_pkt_pkg
//   Shared definitions for the USB receive packet parser: FSM state type,
//   PID class type, PID codes, CRC5 residue constant and the PID class decode.
package usb_rx_pkt_pkg;

    localparam int unsigned MAX_LEN_DEF = 64;
    localparam int unsigned LEN_W_DEF   = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PID,
        ST_BODY,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_HS,
        CLS_DATA,
        CLS_TOKEN,
        CLS_OTHER
    } pid_class_e;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;
    localparam logic [3:0] PID_PRE   = 4'hC;
    localparam logic [3:0] PID_SPLIT = 4'h8;
    localparam logic [3:0] PID_PING  = 4'h4;

    // Remainder left in the CRC5 register after a correct token (data + CRC).
    localparam logic [4:0] CRC5_RESIDUE = 5'b01100;

    function automatic pid_class_e pid_class(input logic [3:0] pid);
        pid_class_e cls;
        case (pid)
            PID_ACK, PID_NAK, PID_STALL, PID_NYET:     cls = CLS_HS;
            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: cls = CLS_DATA;
            PID_OUT, PID_IN, PID_SETUP, PID_SOF:        cls = CLS_TOKEN;
            default:                                    cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/usb_rx_pkt_if.sv
// usb_rx_pkt_if
//   Bundles the byte stream from the bit-level receiver and the per-packet
//   status/payload outputs of the parser.
//   master : receiver side (drives rx_data/rx_valid/rx_active/crc16_valid)
//   slave  : parser side (drives data_out/data_we/pkt_*/busy, tok_* with
//            USB_RX_PKT_TOKEN_EN)
interface usb_rx_pkt_if #(
    parameter int unsigned LEN_W = 7
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_active;
    logic             crc16_valid;
    logic [7:0]       data_out;
    logic             data_we;
    logic             pkt_done;
    logic [3:0]       pkt_pid;
    logic [LEN_W-1:0] pkt_len;
    logic             pkt_pid_err;
    logic             pkt_crc_err;
    logic             pkt_len_err;
    logic             busy;
`ifdef USB_RX_PKT_TOKEN_EN
    logic [6:0]       tok_addr;
    logic [3:0]       tok_endp;
    logic [10:0]      tok_frame;
`endif

    modport master (
        output rx_data, rx_valid, rx_active, crc16_valid,
        input  data_out, data_we, pkt_done, pkt_pid, pkt_len,
               pkt_pid_err, pkt_crc_err, pkt_len_err, busy
`ifdef USB_RX_PKT_TOKEN_EN
        , input tok_addr, tok_endp, tok_frame
`endif
    );

    modport slave (
        input  rx_data, rx_valid, rx_active, crc16_valid,
        output data_out, data_we, pkt_done, pkt_pid, pkt_len,
               pkt_pid_err, pkt_crc_err, pkt_len_err, busy
`ifdef USB_RX_PKT_TOKEN_EN
        , output tok_addr, tok_endp, tok_frame
`endif
    );

endinterface

// File: rtl/usb_rx_pkt_crc5.sv
// usb_crc5
//   USB token CRC5 (x^5 + x^2 + 1), fed LSB-first one byte per enable.
//   Only built with USB_RX_PKT_TOKEN_EN.
//   clk, rst : clock, asynchronous active-high reset
//   init_i   : preset the register to all ones (start of a token)
//   en_i     : fold data_i into the CRC
//   data_i   : byte, bit 0 first
//   crc_o    : current register value (equals residue after a good token)
`ifdef USB_RX_PKT_TOKEN_EN
module usb_crc5 (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [4:0] crc_o
);
    logic [4:0] crc_q;
    logic [4:0] crc_d;
    logic       fb;

    // Serial LFSR unrolled over the eight bits of the byte.
    always_comb begin
        crc_d = crc_q;
        fb    = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            fb    = data_i[i] ^ crc_d[4];
            crc_d = {crc_d[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '1;
        end else if (init_i) begin
            crc_q <= '1;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;
endmodule
`endif

// File: rtl/usb_rx_pkt.sv
// usb_rx_pkt
//   Packet parser behind the USB bit-level receiver. Latches the PID, passes
//   data-packet payload through a 2-byte holdback so the CRC16 bytes never
//   reach data_out, and raises one pkt_done event with status per packet.
//   Optional macro USB_RX_PKT_TOKEN_EN adds token field decode and CRC5 check.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : usb_rx_pkt_if.slave (rx byte stream in, payload/status out)
module usb_rx_pkt
    import usb_rx_pkt_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    usb_rx_pkt_if.slave  bus
);
    state_e           state_q, state_d;
    logic             start_pend_q, start_pend_d;
    logic             rx_active_q;
    logic             rise;
    logic             start;

    logic [3:0]       pid_q;
    logic             pid_chk_err_q;
    pid_class_e       cls_q;
    logic [1:0]       body_cnt_q;     // saturates at 3
    logic [1:0]       hb_cnt_q;
    logic [7:0]       hb0_q, hb1_q;   // hb0 is the oldest held byte
    logic [7:0]       data_out_q;
    logic             data_we_q;
    logic [LEN_W-1:0] len_q;
    logic             ovf_q;
    logic             crc16_bad_q;
    logic             room;

    logic             done;
    logic             pid_err, crc_err, len_err;

    assign rise  = bus.rx_active & ~rx_active_q;
    assign start = (state_q == ST_IDLE) && (rise || start_pend_q);
    // Count the write still in flight so a back-to-back byte sees it.
    assign room  = (len_q + LEN_W'(data_we_q)) < LEN_W'(MAX_LEN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
        end
    end

    // Next state
    always_comb begin
        state_d      = state_q;
        start_pend_d = start_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (rise || start_pend_q) begin
                    state_d      = ST_PID;
                    start_pend_d = 1'b0;
                end
            end
            ST_PID: begin
                if (bus.rx_valid)        state_d = ST_BODY;
                else if (!bus.rx_active) state_d = ST_IDLE;
            end
            ST_BODY: begin
                if (!bus.rx_active) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                // A new packet starting during DONE is remembered for IDLE.
                if (rise) start_pend_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_active_q   <= 1'b0;
            pid_q         <= '0;
            pid_chk_err_q <= 1'b0;
            cls_q         <= CLS_HS;
            body_cnt_q    <= '0;
            hb_cnt_q      <= '0;
            hb0_q         <= '0;
            hb1_q         <= '0;
            data_out_q    <= '0;
            data_we_q     <= 1'b0;
            len_q         <= '0;
            ovf_q         <= 1'b0;
            crc16_bad_q   <= 1'b0;
        end else begin
            rx_active_q <= bus.rx_active;
            data_we_q   <= 1'b0;
            if (data_we_q) len_q <= len_q + LEN_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        body_cnt_q  <= '0;
                        hb_cnt_q    <= '0;
                        len_q       <= '0;
                        ovf_q       <= 1'b0;
                        crc16_bad_q <= 1'b0;
                    end
                end
                ST_PID: begin
                    if (bus.rx_valid) begin
                        pid_q         <= bus.rx_data[3:0];
                        pid_chk_err_q <= bus.rx_data[3:0] != ~bus.rx_data[7:4];
                        cls_q         <= pid_class(bus.rx_data[3:0]);
                    end
                end
                ST_BODY: begin
                    if (bus.rx_valid) begin
                        if (body_cnt_q != 2'd3) body_cnt_q <= body_cnt_q + 2'd1;
                        if (cls_q == CLS_DATA) begin
                            if (hb_cnt_q == 2'd2) begin
                                hb0_q <= hb1_q;
                                hb1_q <= bus.rx_data;
                                if (room) begin
                                    data_out_q <= hb0_q;
                                    data_we_q  <= 1'b1;
                                end else begin
                                    ovf_q <= 1'b1;
                                end
                            end else begin
                                if (hb_cnt_q == 2'd0) hb0_q <= bus.rx_data;
                                else                  hb1_q <= bus.rx_data;
                                hb_cnt_q <= hb_cnt_q + 2'd1;
                            end
                        end
                    end
                    if (!bus.rx_active) crc16_bad_q <= !bus.crc16_valid;
                end
                default: ;
            endcase
        end
    end

`ifdef USB_RX_PKT_TOKEN_EN
    logic [7:0]  tb0_q, tb1_q;
    logic [6:0]  tok_addr_q;
    logic [3:0]  tok_endp_q;
    logic [10:0] tok_frame_q;
    logic [4:0]  crc5;
    logic        crc5_init, crc5_en;

    assign crc5_init = (state_q == ST_PID) && bus.rx_valid;
    assign crc5_en   = (state_q == ST_BODY) && bus.rx_valid && (cls_q == CLS_TOKEN);

    usb_crc5 u_crc5 (
        .clk    (clk),
        .rst    (rst),
        .init_i (crc5_init),
        .en_i   (crc5_en),
        .data_i (bus.rx_data),
        .crc_o  (crc5)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tb0_q       <= '0;
            tb1_q       <= '0;
            tok_addr_q  <= '0;
            tok_endp_q  <= '0;
            tok_frame_q <= '0;
        end else begin
            if (crc5_en && body_cnt_q == 2'd0) tb0_q <= bus.rx_data;
            if (crc5_en && body_cnt_q == 2'd1) tb1_q <= bus.rx_data;
            if (state_q == ST_DONE && cls_q == CLS_TOKEN) begin
                tok_addr_q  <= tb0_q[6:0];
                tok_endp_q  <= {tb1_q[2:0], tb0_q[7]};
                tok_frame_q <= {tb1_q[2:0], tb0_q};
            end
        end
    end

    assign bus.tok_addr  = tok_addr_q;
    assign bus.tok_endp  = tok_endp_q;
    assign bus.tok_frame = tok_frame_q;
`endif

    // Outputs / status
    always_comb begin
        done    = (state_q == ST_DONE);
        pid_err = pid_chk_err_q;
        crc_err = 1'b0;
        len_err = 1'b0;
        case (cls_q)
            CLS_HS: len_err = (body_cnt_q != 2'd0);
            CLS_DATA: begin
                len_err = (body_cnt_q < 2'd2) || ovf_q;
                crc_err = crc16_bad_q;
            end
            CLS_TOKEN: begin
`ifdef USB_RX_PKT_TOKEN_EN
                len_err = (body_cnt_q != 2'd2);
                crc_err = (crc5 != CRC5_RESIDUE);
`else
                pid_err = 1'b1;
`endif
            end
            default: pid_err = 1'b1;
        endcase
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_we     = data_we_q;
    assign bus.pkt_done    = done;
    assign bus.pkt_pid     = done ? pid_q : '0;
    assign bus.pkt_len     = done ? len_q : '0;
    assign bus.pkt_pid_err = done & pid_err;
    assign bus.pkt_crc_err = done & crc_err;
    assign bus.pkt_len_err = done & len_err;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_rx_pkt.sv
// tb_usb_rx_pkt
//   Self-checking bench for usb_rx_pkt: directed vector table, hand-written
//   corner sequences and randomized packets against a packet-level model.
//   Honors USB_RX_PKT_TOKEN_EN like the design.
module tb_usb_rx_pkt;
    import usb_rx_pkt_pkg::*;

    localparam int MAXL = 64;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    usb_rx_pkt_if #(.LEN_W(7)) bus ();

    usb_rx_pkt #(.MAX_LEN(64), .LEN_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] pb;
        int         n;
        bit         crc_ok;
        int         len;
        bit         pe, ce, le;
    } vec_t;

    typedef struct {
        int          len;
        bit          pe, ce, le;
        bit          tok;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] frame;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  body_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_w_q[$];
    vec_t        tab[$];
    int          done_cnt = 0;
    logic [3:0]  d_pid;
    logic [6:0]  d_len;
    logic        d_pe, d_ce, d_le;
    logic [6:0]  d_addr;
    logic [3:0]  d_endp;
    logic [10:0] d_frame;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: collect payload writes and the status of each finished packet.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_we) got_q.push_back(bus.data_out);
            if (bus.pkt_done) begin
                done_cnt++;
                d_pid = bus.pkt_pid;
                d_len = bus.pkt_len;
                d_pe  = bus.pkt_pid_err;
                d_ce  = bus.pkt_crc_err;
                d_le  = bus.pkt_len_err;
`ifdef USB_RX_PKT_TOKEN_EN
                d_addr  = bus.tok_addr;
                d_endp  = bus.tok_endp;
                d_frame = bus.tok_frame;
`else
                d_addr  = '0;
                d_endp  = '0;
                d_frame = '0;
`endif
            end
        end
    end

    // 5-bit CRC field a transmitter places in byte1[7:3] for an 11-bit token value.
    function automatic logic [4:0] crc5_field(input logic [10:0] v);
        logic [4:0] c;
        logic [4:0] f;
        logic       fb;
        c = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb = v[i] ^ c[4];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        for (int k = 0; k < 5; k++) f[k] = ~c[4-k];
        return f;
    endfunction

    // Packet-level reference: expected status and payload from PID and body bytes.
    task automatic model(input logic [7:0] pb, input bit crc_ok, output exp_t e);
        int n;
        int pay;
        e = '{default: 0};
        exp_w_q.delete();
        n = body_q.size();
        e.pe = (pb[3:0] != ~pb[7:4]);
        case (pb[3:0])
            4'h2, 4'hA, 4'hE, 4'h6: e.le = (n > 0);
            4'h3, 4'hB, 4'h7, 4'hF: begin
                pay   = (n >= 2) ? n - 2 : 0;
                e.len = (pay > MAXL) ? MAXL : pay;
                for (int i = 0; i < e.len; i++) exp_w_q.push_back(body_q[i]);
                e.le  = (n < 2) || (pay > MAXL);
                e.ce  = !crc_ok;
            end
            4'h1, 4'h9, 4'hD, 4'h5: begin
`ifdef USB_RX_PKT_TOKEN_EN
                e.le  = (n != 2);
                if (n == 2) begin
                    e.tok   = 1'b1;
                    e.addr  = body_q[0][6:0];
                    e.endp  = {body_q[1][2:0], body_q[0][7]};
                    e.frame = {body_q[1][2:0], body_q[0]};
                    e.ce    = (body_q[1][7:3] != crc5_field({body_q[1][2:0], body_q[0]}));
                end
`else
                e.pe = 1'b1;
`endif
            end
            default: e.pe = 1'b1;
        endcase
    endtask

    task automatic send_pkt(input logic [7:0] pb, input bit crc_ok,
                            input int unsigned maxgap, input int post);
        bus.crc16_valid = 1'b0;
        bus.rx_active   = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_data  = pb;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        foreach (body_q[i]) begin
            bus.rx_data  = body_q[i];
            bus.rx_valid = 1'b1;
            @(negedge clk);
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
        end
        bus.crc16_valid = crc_ok;
        bus.rx_active   = 1'b0;
        repeat (post) @(negedge clk);
    endtask

    task automatic do_pkt(input string tag, input logic [7:0] pb, input bit crc_ok,
                          input exp_t e, input int unsigned maxgap);
        int d0;
        int bad;
        got_q.delete();
        d0 = done_cnt;
        send_pkt(pb, crc_ok, maxgap, 6);
        for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge clk);
        chk({tag, ".done"},   done_cnt - d0, 1);
        chk({tag, ".pid"},    d_pid, pb[3:0]);
        chk({tag, ".len"},    d_len, e.len);
        chk({tag, ".piderr"}, d_pe, e.pe);
        chk({tag, ".crcerr"}, d_ce, e.ce);
        chk({tag, ".lenerr"}, d_le, e.le);
        chk({tag, ".nwr"},    got_q.size(), exp_w_q.size());
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_w_q.size(); i++)
            if (got_q[i] !== exp_w_q[i]) bad++;
        chk({tag, ".wdata_bad"}, bad, 0);
        if (e.tok) begin
            chk({tag, ".addr"},  d_addr, e.addr);
            chk({tag, ".endp"},  d_endp, e.endp);
            chk({tag, ".frame"}, d_frame, e.frame);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        exp_t       e;
        logic [3:0] p;
        logic [7:0] pb;
        bit         crc_ok;
        int         n;
        int         d0;

        rst = 1'b1;
        bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_active = 1'b0; bus.crc16_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.data_we",  bus.data_we, 0);
        chk("rst.data_out", bus.data_out, 0);
        chk("rst.done",     bus.pkt_done, 0);
        chk("rst.pid",      bus.pkt_pid, 0);
        chk("rst.len",      bus.pkt_len, 0);
        chk("rst.errs",     {bus.pkt_pid_err, bus.pkt_crc_err, bus.pkt_len_err}, 0);
        chk("rst.busy",     bus.busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table: body bytes are 1,2,3..; payload written is 1..len.
        tab.push_back('{8'hD2,  0, 1'b1,  0, 1'b0, 1'b0, 1'b0}); // ACK
        tab.push_back('{8'hC3,  5, 1'b1,  3, 1'b0, 1'b0, 1'b0}); // DATA0 3 payload
        tab.push_back('{8'hC4,  0, 1'b1,  0, 1'b1, 1'b0, 1'b0}); // bad PID
        tab.push_back('{8'h5A,  1, 1'b1,  0, 1'b0, 1'b0, 1'b1}); // NAK + stray byte
        tab.push_back('{8'h4B, 67, 1'b1, 64, 1'b0, 1'b0, 1'b1}); // DATA1 overflow
        tab.push_back('{8'h4B, 66, 1'b0, 64, 1'b0, 1'b1, 1'b0}); // DATA1 max, bad CRC
        tab.push_back('{8'hC3,  1, 1'b1,  0, 1'b0, 1'b0, 1'b1}); // DATA0 too short
        tab.push_back('{8'h87,  2, 1'b1,  0, 1'b0, 1'b0, 1'b0}); // DATA2 empty payload
        tab.push_back('{8'h0F,  4, 1'b1,  2, 1'b0, 1'b0, 1'b0}); // MDATA
        tab.push_back('{8'h33,  4, 1'b1,  2, 1'b1, 1'b0, 1'b0}); // check field wrong
        tab.push_back('{8'h1E,  2, 1'b1,  0, 1'b0, 1'b0, 1'b1}); // STALL + 2 bytes
`ifndef USB_RX_PKT_TOKEN_EN
        tab.push_back('{8'h69,  2, 1'b1,  0, 1'b1, 1'b0, 1'b0}); // IN unsupported
`endif
        for (int i = 0; i < tab.size(); i++) begin
            body_q.delete();
            exp_w_q.delete();
            for (int b = 0; b < tab[i].n; b++) body_q.push_back(8'(b + 1));
            for (int b = 0; b < tab[i].len; b++) exp_w_q.push_back(8'(b + 1));
            e     = '{default: 0};
            e.len = tab[i].len;
            e.pe  = tab[i].pe;
            e.ce  = tab[i].ce;
            e.le  = tab[i].le;
            do_pkt($sformatf("tab%0d", i), tab[i].pb, tab[i].crc_ok, e, (i % 3));
        end

        // SETUP tokens: good and corrupted CRC5.
        body_q.delete(); body_q.push_back(8'h00); body_q.push_back(8'h10);
        exp_w_q.delete();
        e = '{default: 0};
`ifdef USB_RX_PKT_TOKEN_EN
        e.tok = 1'b1;
`else
        e.pe = 1'b1;
`endif
        do_pkt("setup_ok", 8'h2D, 1'b1, e, 1);
        body_q[1] = 8'h11;
        e.frame = 11'h100;
`ifdef USB_RX_PKT_TOKEN_EN
        e.ce = 1'b1;
`endif
        do_pkt("setup_bad", 8'h2D, 1'b1, e, 1);

        // Back-to-back ACKs: second rise lands in the DONE cycle of the first.
        body_q.delete();
        d0 = done_cnt;
        send_pkt(8'hD2, 1'b1, 0, 1);
        send_pkt(8'hD2, 1'b1, 0, 6);
        for (int i = 0; i < 20 && done_cnt - d0 < 2; i++) @(negedge clk);
        chk("b2b.done", done_cnt - d0, 2);
        chk("b2b.pid",  d_pid, 2);
        chk("b2b.errs", {d_pe, d_ce, d_le}, 0);

        // Reset in the middle of a DATA0 packet.
        d0 = done_cnt;
        bus.rx_active = 1'b1;
        repeat (3) @(negedge clk);
        pb = 8'hC3;
        for (int b = 0; b < 4; b++) begin
            bus.rx_data  = pb;
            bus.rx_valid = 1'b1;
            @(negedge clk);
            bus.rx_valid = 1'b0;
            pb = 8'(b + 1);
        end
        chk("mid.data_we",  bus.data_we, 1);
        chk("mid.data_out", bus.data_out, 8'h01);
        rst = 1'b1;
        #1;
        chk("mid_rst.data_we",  bus.data_we, 0);
        chk("mid_rst.data_out", bus.data_out, 0);
        chk("mid_rst.busy",     bus.busy, 0);
        chk("mid_rst.done",     bus.pkt_done, 0);
        bus.rx_active = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_rst.no_event", done_cnt - d0, 0);
        body_q.delete(); exp_w_q.delete();
        e = '{default: 0};
        do_pkt("post_rst_ack", 8'hD2, 1'b1, e, 0);

        // Empty packet: rx_active pulse without any byte.
        d0 = done_cnt;
        bus.rx_active = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_active = 1'b0;
        repeat (8) @(negedge clk);
        chk("empty.no_event", done_cnt - d0, 0);
        chk("empty.busy",     bus.busy, 0);

        // Randomized packets against the model.
        for (int r = 0; r < 40; r++) begin
            p  = 4'($urandom_range(0, 15));
            pb = {~p, p};
            if ($urandom_range(0, 9) == 0) pb[7:4] = 4'($urandom_range(0, 15));
            body_q.delete();
            if (p inside {4'h3, 4'hB, 4'h7, 4'hF})
                n = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 8) : $urandom_range(60, 70);
            else
                n = $urandom_range(0, 3);
`ifdef USB_RX_PKT_TOKEN_EN
            if (p inside {4'h1, 4'h9, 4'hD, 4'h5}) n = 2;
`endif
            for (int b = 0; b < n; b++) body_q.push_back(8'($urandom_range(0, 255)));
`ifdef USB_RX_PKT_TOKEN_EN
            if (n == 2 && p inside {4'h1, 4'h9, 4'hD, 4'h5} && $urandom_range(0, 1) == 1)
                body_q[1][7:3] = crc5_field({body_q[1][2:0], body_q[0]});
`endif
            crc_ok = 1'($urandom_range(0, 1));
            model(pb, crc_ok, e);
            do_pkt($sformatf("rnd%0d", r), pb, crc_ok, e, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
